issue_instr_buffer: RTL and testbench
=====================================

# issue_instr_buffer

Decoupling FIFO between the fetch stage and the issue stage. It accepts fetched instructions with their branch prediction and fetch-exception information through a valid/ready handshake, and presents them in order to the issue logic. It absorbs issue back-pressure so the fetch memory interface can keep requests in flight. It also stops accepting new entries after a faulting fetch until the pipeline is flushed.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards every entry and clears the fault lock.
- fetch_valid_i  in  1  fetch stage offers an entry.
- fetch_ready_o  out  1  buffer can accept the entry.
- fetch_instr_i  in  len5_pkg::ILEN  fetched instruction word.
- fetch_pred_i  in  fetch_pkg::prediction_t  prediction attached to the instruction.
- fetch_except_raised_i  in  1  the fetch raised an exception.
- fetch_except_code_i  in  fetch_pkg::except_code_t  exception code.
- issue_valid_o  out  1  head entry is valid.
- issue_ready_i  in  1  issue stage consumes the head entry.
- issue_instr_o  out  len5_pkg::ILEN  head instruction.
- issue_pred_o  out  fetch_pkg::prediction_t  head prediction.
- issue_except_raised_o  out  1  head entry carries an exception.
- issue_except_code_o  out  fetch_pkg::except_code_t  head exception code.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer with a head pointer and a tail pointer, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus a count register.
- Push occurs when fetch_valid_i and fetch_ready_o are both high. The entry is written at the tail and the tail advances.
- Pop occurs when issue_valid_o and issue_ready_i are both high. The head advances.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal when full, because the pop frees the slot in the same cycle, so fetch_ready_o is high when full and issue_ready_i is high.
- fetch_ready_o = !locked & (count < DEPTH | issue_ready_i).
- issue_valid_o = (count != 0). The issue_* outputs are driven from the head entry and are don't-care while issue_valid_o is low.
- Fault lock, state machine with states RUN and LOCKED:
  - RUN to LOCKED: on a push with fetch_except_raised_i = 1.
  - LOCKED to RUN: on flush_i only.
  - While LOCKED, fetch_ready_o = 0. Already-buffered entries, including the faulting one, still drain to issue.
- flush_i has priority over any push or pop in the same cycle. The next state is count = 0, pointers = 0, state RUN, and nothing is written.
- Reset is equivalent to flush and is asynchronous. Entry payload registers need not be reset.
- Reset values: issue_valid_o = 0, count_o = 0, fetch_ready_o = 1 (as soon as rst_ni is high), state RUN.

## Timing
- Without the bypass option, latency is exactly 1 cycle: an entry pushed in cycle N is visible at issue in cycle N+1.
- Throughput is one push and one pop per cycle.
- Combinational paths:
  - fetch_ready_o depends on issue_ready_i.
  - No path from fetch_valid_i to fetch_ready_o.
  - No path from issue_ready_i to issue_valid_o.
- Mid-operation reset aborts immediately; no partial entry survives.

## Configuration
- ISSUE_BUF_BYPASS_EN defined: when count = 0 and fetch_valid_i = 1 with the lock clear, the fetch_* inputs drive issue_* combinationally and issue_valid_o = 1.
  - If issue_ready_i is also high, the entry is consumed in the same cycle and is not stored; count stays 0.
  - Otherwise it is stored as a normal push.
  - Adds a fetch_valid_i to issue_valid_o path; latency becomes 0.
- Not defined: no bypass; behaviour as in Operation and Timing.

## Test plan
- Fill then drain, DEPTH=4: push 0x00000013, 0x00100093, 0x00200113, 0x00300193 with issue_ready_i=0.
  - Required: count_o=4, fetch_ready_o=0.
  - Then raise issue_ready_i: the four words appear in order on consecutive cycles and count_o returns to 0.
- Full with concurrent push and pop: at count=4, drive fetch_valid_i=1 and issue_ready_i=1 for 8 cycles.
  - Required: count_o stays 4, fetch_ready_o=1, and output order is preserved across pointer wrap-around.
- Fault lock: push A, then B with except_raised=1 and code 0x1, then offer C.
  - Required: fetch_ready_o=0 after B is pushed and C is never accepted.
  - A, then B with issue_except_code_o=0x1, drain; count_o ends at 0.
  - After a one-cycle flush_i, fetch_ready_o=1.
- Flush priority: at count=3, assert flush_i with fetch_valid_i=1 and issue_ready_i=1.
  - Required: next cycle count_o=0, issue_valid_o=0, and the pushed word never appears.
- Asynchronous reset mid-stream: drop rst_ni between clock edges with count=2.
  - Required: issue_valid_o=0 and count_o=0 immediately, not at the next edge.
  - After release, the first pushed entry appears one cycle later with the macro off, or in the same cycle with ISSUE_BUF_BYPASS_EN on.
- Bypass (macro on): with the buffer empty, push 0xDEADBEEF with issue_ready_i=1.
  - Required: issue_valid_o=1 and issue_instr_o=0xDEADBEEF in the same cycle, and count_o remains 0.

Source files
------------

// File: rtl/issue_instr_buffer_if.sv
// Shared types and the fetch/issue bundle used by issue_instr_buffer.
// The buffer sits on the slave modport; the fetch/issue side drives the master modport.
package len5_pkg;
  localparam int ILEN = 32;
endpackage

package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } prediction_t;

  typedef logic [3:0] except_code_t;
endpackage

interface issue_instr_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                           fetch_valid_i;
  logic                           fetch_ready_o;
  logic [len5_pkg::ILEN-1:0]      fetch_instr_i;
  fetch_pkg::prediction_t         fetch_pred_i;
  logic                           fetch_except_raised_i;
  fetch_pkg::except_code_t        fetch_except_code_i;
  logic                           issue_valid_o;
  logic                           issue_ready_i;
  logic [len5_pkg::ILEN-1:0]      issue_instr_o;
  fetch_pkg::prediction_t         issue_pred_o;
  logic                           issue_except_raised_o;
  fetch_pkg::except_code_t        issue_except_code_o;
  logic [CNT_W-1:0]               count_o;

  modport slave (
    input  fetch_valid_i, fetch_instr_i, fetch_pred_i,
    input  fetch_except_raised_i, fetch_except_code_i, issue_ready_i,
    output fetch_ready_o, issue_valid_o, issue_instr_o, issue_pred_o,
    output issue_except_raised_o, issue_except_code_o, count_o
  );

  modport master (
    output fetch_valid_i, fetch_instr_i, fetch_pred_i,
    output fetch_except_raised_i, fetch_except_code_i, issue_ready_i,
    input  fetch_ready_o, issue_valid_o, issue_instr_o, issue_pred_o,
    input  issue_except_raised_o, issue_except_code_o, count_o
  );
endinterface

// File: rtl/issue_instr_buffer.sv
// Fetch-to-issue decoupling FIFO with a fault lock that blocks new entries after a faulting fetch.
// Optional ISSUE_BUF_BYPASS_EN: an empty buffer forwards the fetch entry straight to issue.
module issue_instr_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  issue_instr_buffer_if.slave        bus
);
  import fetch_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [len5_pkg::ILEN-1:0] instr;
    prediction_t               pred;
    logic                      except_raised;
    except_code_t              except_code;
  } entry_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  entry_t           mem_r [DEPTH];

  entry_t           fetch_entry_s;
  entry_t           issue_entry_s;
  logic             fetch_ready_s;
  logic             issue_valid_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
`ifdef ISSUE_BUF_BYPASS_EN
  logic             bypass_s;
`endif

  assign fetch_entry_s = '{
    instr:         bus.fetch_instr_i,
    pred:          bus.fetch_pred_i,
    except_raised: bus.fetch_except_raised_i,
    except_code:   bus.fetch_except_code_i
  };

  // Handshake decode; a full buffer still accepts when the head leaves this cycle.
  always_comb begin
    fetch_ready_s = (state_r == RUN) && ((count_r < DEPTH_C) || bus.issue_ready_i);
    accept_s      = bus.fetch_valid_i && fetch_ready_s;
`ifdef ISSUE_BUF_BYPASS_EN
    bypass_s      = (count_r == CNT_ZERO) && bus.fetch_valid_i && (state_r == RUN);
    issue_valid_s = (count_r != CNT_ZERO) || bypass_s;
    if (bypass_s) begin
      issue_entry_s = fetch_entry_s;
    end else begin
      issue_entry_s = mem_r[head_r];
    end
    // A bypassed entry consumed in the same cycle is never stored.
    push_s        = accept_s && !(bypass_s && bus.issue_ready_i);
    pop_s         = (count_r != CNT_ZERO) && bus.issue_ready_i;
`else
    issue_valid_s = (count_r != CNT_ZERO);
    issue_entry_s = mem_r[head_r];
    push_s        = accept_s;
    pop_s         = issue_valid_s && bus.issue_ready_i;
`endif
  end

  // Fault-lock next state: lock on an accepted faulting entry, release only on flush.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN: begin
        if (flush_i) begin
          state_s = RUN;
        end else if (accept_s && bus.fetch_except_raised_i) begin
          state_s = LOCKED;
        end else begin
          state_s = RUN;
        end
      end
      LOCKED: begin
        if (flush_i) begin
          state_s = RUN;
        end else begin
          state_s = LOCKED;
        end
      end
      default: state_s = RUN;
    endcase
  end

  // Control state: pointers, occupancy and lock; flush overrides any push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= RUN;
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (flush_i) begin
      state_r <= RUN;
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage; stale slots are harmless because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_i) begin
      mem_r[tail_r] <= fetch_entry_s;
    end
  end

  assign bus.fetch_ready_o         = fetch_ready_s;
  assign bus.issue_valid_o         = issue_valid_s;
  assign bus.issue_instr_o         = issue_entry_s.instr;
  assign bus.issue_pred_o          = issue_entry_s.pred;
  assign bus.issue_except_raised_o = issue_entry_s.except_raised;
  assign bus.issue_except_code_o   = issue_entry_s.except_code;
  assign bus.count_o               = count_r;
endmodule

// File: tb/tb_issue_instr_buffer.sv
// Directed bench for issue_instr_buffer: a reference queue holds the expected entries
// and every cycle checks handshake flags, occupancy and the head payload.
module tb_issue_instr_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
`ifdef ISSUE_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]  instr;
    prediction_t  pred;
    logic         exc;
    except_code_t code;
  } ent_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  ent_t q[$];
  int   cnt = 0;
  bit   lock = 1'b0;

  always #5 clk = ~clk;

  issue_instr_buffer_if #(.DEPTH(DEPTH)) bus ();

  issue_instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic prediction_t mkpred(input logic [31:0] w);
    prediction_t p;
    p.pc     = w ^ 32'h5555_5555;
    p.target = w + 32'd4;
    p.taken  = w[0];
    return p;
  endfunction

  task automatic drive(input logic fv, input logic [31:0] w, input logic exc,
                       input logic [3:0] code, input logic ir, input logic fl);
    bus.fetch_valid_i         = fv;
    bus.fetch_instr_i         = w;
    bus.fetch_pred_i          = mkpred(w);
    bus.fetch_except_raised_i = exc;
    bus.fetch_except_code_i   = code;
    bus.issue_ready_i         = ir;
    flush_i                   = fl;
  endtask

  // Sample mid-cycle, compare against the reference, then advance it across the edge.
  task automatic cycle();
    ent_t cur;
    ent_t head;
    bit   byp;
    bit   er;
    bit   ev;
    bit   fv;
    bit   ir;
    #3;
    fv   = bus.fetch_valid_i;
    ir   = bus.issue_ready_i;
    cur  = {bus.fetch_instr_i, bus.fetch_pred_i, bus.fetch_except_raised_i, bus.fetch_except_code_i};
    byp  = BYP && (cnt == 0) && fv && !lock;
    er   = !lock && ((cnt < DEPTH) || ir);
    ev   = (cnt != 0) || byp;
    chk("fetch_ready", 128'(bus.fetch_ready_o), 128'(er));
    chk("issue_valid", 128'(bus.issue_valid_o), 128'(ev));
    chk("count", 128'(bus.count_o), 128'(cnt));
    if (ev) begin
      head = (cnt != 0) ? q[0] : cur;
      chk("issue_instr", 128'(bus.issue_instr_o), 128'(head.instr));
      chk("issue_pred", 128'(bus.issue_pred_o), 128'(head.pred));
      chk("issue_exc", 128'(bus.issue_except_raised_o), 128'(head.exc));
      if (head.exc) begin
        chk("issue_code", 128'(bus.issue_except_code_o), 128'(head.code));
      end
    end
    if (flush_i) begin
      q.delete();
      cnt  = 0;
      lock = 1'b0;
    end else begin
      if (ev && ir && (cnt != 0)) begin
        void'(q.pop_front());
        cnt--;
      end
      if (fv && er && !(byp && ir)) begin
        q.push_back(cur);
        cnt++;
      end
      if (fv && er && cur.exc) begin
        lock = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] fill_w [4];
    fill_w[0] = 32'h0000_0013;
    fill_w[1] = 32'h0010_0093;
    fill_w[2] = 32'h0020_0113;
    fill_w[3] = 32'h0030_0193;

    // reset state
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 128'(bus.count_o), 128'(0));
    chk("rst_valid", 128'(bus.issue_valid_o), 128'(0));
    rst_ni = 1'b1;
    cycle();

    // fill then drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_w[i], 1'b0, 4'h0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    repeat (4) cycle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle();

    // full with concurrent push and pop across wrap-around
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_1000 + 32'(i), 1'b0, 4'h0, 1'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h0000_2000 + 32'(i), 1'b0, 4'h0, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    repeat (5) cycle();

    // fault lock
    drive(1'b1, 32'hAAAA_0001, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hBBBB_0002, 1'b1, 4'h1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hCCCC_0003, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (2) cycle();
    drive(1'b1, 32'hCCCC_0003, 1'b0, 4'h0, 1'b1, 1'b0);
    repeat (3) cycle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle();

    // flush priority at count=3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_3000 + 32'(i), 1'b0, 4'h0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'hF1F1_F1F1, 1'b0, 4'h0, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    repeat (2) cycle();

    // asynchronous reset mid-stream at count=2
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_4000 + 32'(i), 1'b0, 4'h0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 128'(bus.issue_valid_o), 128'(0));
    chk("async_rst_count", 128'(bus.count_o), 128'(0));
    q.delete();
    cnt  = 0;
    lock = 1'b0;
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h1234_5678, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    repeat (2) cycle();

    // empty buffer, push with issue ready
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 4'h0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
